// File: rtl/sram_port_ctrl_pkg.sv
// Shared constants and helpers for the SRAM port controller.
// Width helpers size FIFO pointers and counters.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int BYTES      = DEF_DATA_W / 8;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response stream bundle between an initiator
// and the SRAM port controller.
interface sram_port_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_mask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_mask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/sram_port_ctrl_resp_fifo.sv
// Read-response FIFO: synchronous push/pop, occupancy
// count, pointers wrap modulo DEPTH.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 32,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign dout   = mem[rp];

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)   wp <= inc(wp);
      if (do_pop) rp <= inc(rp);
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// One-port front end for the SRAM2RW byte-masked macros:
// request stream to CSB/WEB/OEB strobes, read data to a FIFO.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RESP_DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_port_ctrl_if.slave     bus,
  output logic                sram_csb,
  output logic                sram_web,
  output logic                sram_oeb,
  output logic [DATA_W/8-1:0] sram_bytemask,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_i,
  input  logic [DATA_W-1:0]   sram_o
);

  localparam int CW = clog2(RESP_DEPTH + 1);

  logic          rd_inflight;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          fire;
  logic          rd_fire;
  logic          wr_fire;

  // Occupancy reserves a slot per read in flight; a same-cycle
  // pop is not credited, keeping ready free of resp_ready.
  assign occ = {1'b0, count} + {{CW{1'b0}}, rd_inflight};
  assign bus.req_ready =
    rst_n && (occ < (CW + 1)'(RESP_DEPTH));

  assign fire    = bus.req_valid && bus.req_ready;
  assign rd_fire = fire && !bus.req_write;
  assign wr_fire = fire && bus.req_write
                   && (|bus.req_mask);

  assign sram_a   = bus.req_addr;
  assign sram_i   = bus.req_wdata;
  assign sram_oeb = !rd_inflight;

  always_comb begin
    sram_csb      = 1'b1;
    sram_web      = 1'b1;
    sram_bytemask = '0;
    unique case (1'b1)
      rd_fire: sram_csb = 1'b0;
      wr_fire: begin
        sram_csb      = 1'b0;
        sram_web      = 1'b0;
        sram_bytemask = bus.req_mask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_inflight <= 1'b0;
    else        rd_inflight <= rd_fire;
  end

  assign bus.resp_valid = (count != '0);

  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_inflight),
    .din   (sram_o),
    .pop   (bus.resp_valid && bus.resp_ready),
    .dout  (bus.resp_rdata),
    .count (count)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Scoreboard bench for sram_port_ctrl with a behavioural
// SRAM2RW32x32M port model.
module tb_sram_port_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RD = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sram_csb, sram_web, sram_oeb;
  logic [3:0]    sram_bytemask;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_i;
  logic [DW-1:0] sram_o;
  logic [DW-1:0] o_q;
  logic          init_mem;
  logic          rand_phase = 1'b0;
  logic          rr_fixed = 1'b1;
  logic          rr_rand = 1'b1;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_q [$];
  int            pops [$];
  int            nvec = 0;
  int            nerr = 0;
  int            cyc = 0;
  int            stalls = 0;

  sram_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

  sram_port_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(RD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (b),
    .sram_csb      (sram_csb),
    .sram_web      (sram_web),
    .sram_oeb      (sram_oeb),
    .sram_bytemask (sram_bytemask),
    .sram_a        (sram_a),
    .sram_i        (sram_i),
    .sram_o        (sram_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign b.resp_ready = rand_phase ? rr_rand : rr_fixed;
  always @(negedge clk) rr_rand <= 1'($urandom_range(0, 1));

  // Macro model: one-cycle read latency, O only driven with OEB low
  always @(posedge clk) begin
    if (init_mem) begin
      for (int j = 0; j < 32; j++) mem[j] <= '0;
    end else if (!sram_csb) begin
      if (!sram_web) begin
        for (int k = 0; k < 4; k++)
          if (sram_bytemask[k])
            mem[sram_a][8*k +: 8] <= sram_i[8*k +: 8];
      end else begin
        o_q <= mem[sram_a];
      end
    end
  end
  assign sram_o = sram_oeb ? 32'hDEADBEEF : o_q;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && b.resp_valid && b.resp_ready) begin
      pops.push_back(cyc);
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_resp: got %0h want none",
                 b.resp_rdata);
      end else begin
        chk("resp_rdata", b.resp_rdata, exp_q.pop_front());
      end
    end
    if (rst_n === 1'b1 && dut.u_fifo.count == RD
        && dut.rd_inflight
        && !(b.resp_valid && b.resp_ready)) begin
      nvec++;
      nerr++;
      $display("FAIL fifo_overflow: got push at count %0d want none",
               dut.u_fifo.count);
    end
  end

  task automatic send(input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      input logic [31:0] e);
    int n;
    logic [10:0] es;
    n = 0;
    b.req_valid = 1'b1;
    b.req_write = w;
    b.req_addr  = a;
    b.req_wdata = d;
    b.req_mask  = m;
    #1;
    while (!b.req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
      stalls++;
    end
    if (!b.req_ready) begin
      nvec++;
      nerr++;
      $display("FAIL req_ready_timeout: got 0 want 1 addr %0d", a);
    end else begin
      if (!w)          es = {1'b0, 1'b1, 4'h0, a};
      else if (m != 0) es = {1'b0, 1'b0, m, a};
      else             es = {1'b1, 1'b1, 4'h0, a};
      chk("strobes", {sram_csb, sram_web, sram_bytemask, sram_a}, es);
      chk("sram_i", sram_i, d);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (m[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    b.req_valid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    send(1'b1, a, d, m, 32'h0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e);
    send(1'b0, a, 32'h0, 4'h0, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic w;
    logic [4:0] a;
    for (int j = 0; j < 32; j++) ref_mem[j] = '0;
    rst_n       = 1'b0;
    init_mem    = 1'b1;
    b.req_valid = 1'b0;
    b.req_write = 1'b0;
    b.req_addr  = '0;
    b.req_wdata = '0;
    b.req_mask  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state",
        {b.resp_valid, sram_csb, sram_web, sram_oeb,
         sram_bytemask, b.req_ready},
        {1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0});
    @(negedge clk);
    rst_n    = 1'b1;
    init_mem = 1'b0;
    #1;
    chk("ready_after_reset", b.req_ready, 1'b1);
    @(negedge clk);

    wr(5, 32'hAABBCCDD, 4'b1111);
    wr(5, 32'h11223344, 4'b0101);
    rd(5, 32'hAA22CC44);
    #1;
    chk("lat_n1_no_valid", b.resp_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("lat_n2_valid", b.resp_valid, 1'b1);
    drain();

    wr(3, 32'h12345678, 4'b1111);
    wr(3, 32'hFFFFFFFF, 4'b0000);
    rd(3, 32'h12345678);
    drain();

    wr(9, 32'hCAFEF00D, 4'b1111);
    rd(9, 32'hCAFEF00D);
    drain();

    for (int i = 0; i < 8; i++)
      wr(5'(i), 32'h01010101 * i, 4'b1111);
    pops.delete();
    stalls = 0;
    for (int i = 0; i < 8; i++)
      rd(5'(i), 32'h01010101 * i);
    chk("thru_no_stall", stalls, 0);
    drain();
    chk("thru_resp_count", pops.size(), 8);
    if (pops.size() == 8)
      chk("thru_consecutive", pops[7] - pops[0], 7);

    rr_fixed = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      b.req_addr  = 5'(acc);
      b.req_write = 1'b0;
      b.req_valid = 1'b1;
      #1;
      if (b.req_ready) begin
        exp_q.push_back(32'h01010101 * acc);
        acc++;
      end
      @(negedge clk);
    end
    b.req_valid = 1'b0;
    #1;
    chk("bp_accepted", acc, 3);
    chk("bp_ready_low", b.req_ready, 1'b0);
    rr_fixed = 1'b1;
    drain();

    rr_fixed = 1'b0;
    rd(0, 32'h0);
    rd(1, 32'h01010101);
    rd(2, 32'h02020202);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        {b.resp_valid, sram_csb, sram_web, sram_oeb, b.req_ready},
        {1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset_ready", b.req_ready, 1'b1);
    rr_fixed = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("midreset_no_stale", b.resp_valid, 1'b0);

    rand_phase = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 9));
      if (w)
        wr(a, $urandom, 4'($urandom_range(0, 15)));
      else
        rd(a, ref_mem[a]);
    end
    rand_phase = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
Initiator-side front end for one port of the byte-masked dual-port SRAM macros (SRAM2RW{16,32,64,128}x32M). It converts a valid/ready request stream into the macros' active-low CSB/WEB/OEB, BYTEMASK, A and I strobes, and captures read data from O after the 1-cycle macro latency. Read data is buffered in a response FIFO so that consumer backpressure never drops data. One instance drives one macro port; a dual-port macro uses two instances. The macro's CE is tied to clk at the instantiation site.

Parameters:
ADDR_W, 5, SRAM address width (4/5/6/7 for 16/32/64/128 entries)
DATA_W, 32, data width; must be a multiple of 8
RESP_DEPTH, 3, maximum read responses in flight plus queued; must be >= 1; 3 sustains 1 read/cycle

Ports:
clk  in  1  system clock; also drives macro CE
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready (fire)
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_mask  in  DATA_W/8  byte enables for writes; ignored on reads
resp_valid  out  1  read data valid
resp_ready  in  1  consumer ready
resp_rdata  out  DATA_W  read data, oldest first
sram_csb  out  1  chip select, active low
sram_web  out  1  write enable, active low
sram_oeb  out  1  output enable, active low
sram_bytemask  out  DATA_W/8  byte mask, active high
sram_a  out  ADDR_W  address
sram_i  out  DATA_W  write data
sram_o  in  DATA_W  macro read data

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, rd_inflight=0. Outputs: resp_valid=0, sram_csb=1, sram_web=1, sram_oeb=1, sram_bytemask=0, req_ready=0 while rst_n=0. Reset mid-transaction discards in-flight and queued reads; no response is produced for them.
- Occupancy = fifo_count + rd_inflight. req_ready = rst_n && occupancy < RESP_DEPTH. This holds for reads and writes alike, so ready never depends on req_write. Occupancy does not credit a same-cycle pop, so there is no resp_ready→req_ready combinational path.
- SRAM drive, combinational in the fire cycle (the macro samples at the next clk rise):
  - sram_a = req_addr and sram_i = req_wdata at all times.
  - Read fire: csb=0, web=1, bytemask=0.
  - Write fire with req_mask≠0: csb=0, web=0, bytemask=req_mask.
  - Write fire with req_mask=0: accepted as a no-op; csb=1, web=1.
  - No fire: csb=1, web=1, bytemask=0.
- rd_inflight is a register, set on a read fire and cleared otherwise. While rd_inflight=1: sram_oeb=0, and sram_o is pushed into the FIFO at the end of that cycle. sram_oeb=1 otherwise.
- Read latency: request fire at cycle N produces resp_valid at cycle N+2 at the earliest, with data pushed at the end of N+1.
- FIFO:
  - resp_valid = fifo_count≠0; resp_rdata = head entry.
  - Pop on resp_valid&&resp_ready.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo RESP_DEPTH.
  - Overflow is impossible by construction; the bench asserts this.
- Ordering: responses are returned in read-issue order. Writes produce no response and do not reorder reads.
- Read-after-write to the same address in consecutive cycles returns the new data, since the macro write completes at the edge before the read edge.

Decomposition:
- Package sram_ctrl_pkg: localparam BYTES=DATA_W/8; a function clog2 for FIFO pointer and count widths.
- Sub-module sram_resp_fifo (DEPTH, WIDTH): synchronous FIFO with push/pop and count, async active-low reset. Roughly 80 lines.

Test Plan:
- Reset: assert rst_n=0 mid-read with rd_inflight=1 and 2 entries queued → immediately resp_valid=0, csb=1, web=1, oeb=1. After release, no stale response appears and req_ready=1 next cycle.
- Masked write then read: write addr 5 data 0xAABBCCDD mask 4'b1111, then write addr 5 data 0x11223344 mask 4'b0101, then read addr 5 → resp_rdata=0xAA22CC44 two cycles after the read fire.
- Zero-mask write: write addr 3 mask 0 data 0xFFFFFFFF after a preload of 0x12345678 → csb stays 1 in the fire cycle; read addr 3 returns 0x12345678.
- Throughput: 8 back-to-back reads addr 0..7 (preloaded with addr*0x01010101), resp_ready=1 → req_ready never drops; 8 responses on consecutive cycles, in order.
- Backpressure: resp_ready=0, issue reads continuously → exactly 3 accepted, then req_ready=0. Raise resp_ready → data is returned in order with none lost or duplicated.
- Read-after-write: write addr 9 0xCAFEF00D, read addr 9 in the next cycle → resp_rdata=0xCAFEF00D. Write/read interleaved with resp_ready toggling randomly → ordering is preserved.
